// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between the MEM stage and the byte-lane data memory.
// The master issues requests; the slave (the memory) returns load data and status strobes.
interface dmem_bytelane_if #(
  parameter int unsigned BUS_SIZE   = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  unsignedLd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BUS_SIZE-1:0]   writeData;
  logic [BUS_SIZE-1:0]   readData;
  logic                  rdValid;
  logic                  ready;
  logic                  err;

  modport master (
    output req, we, size, unsignedLd, addr, writeData,
    input  readData, rdValid, ready, err
  );

  modport slave (
    input  req, we, size, unsignedLd, addr, writeData,
    output readData, rdValid, ready, err
  );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory with sb/sh/sw lane enables, extended loads, misalignment
// rejection and a post-reset clear sequencer. Loads return one cycle after acceptance.
module dmem_bytelane #(
  parameter int unsigned BUS_SIZE   = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  dmem_bytelane_if.slave bus
);
  localparam int unsigned IdxW    = ADDR_WIDTH - 2;
  localparam int unsigned Depth   = 2 ** IdxW;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     clr_ptr_q;
  logic [BUS_SIZE-1:0] read_data_q;
  logic                rd_valid_q;
  logic                err_q;

  logic [BUS_SIZE-1:0] mem [Depth];

  logic [IdxW-1:0]     idx;
  logic [1:0]          off;
  logic                accept;
  logic                misalign;
  logic                do_store;
  logic                do_load;
  logic [BUS_SIZE-1:0] rd_word;
  logic [BUS_SIZE-1:0] ld_data;
  logic [BUS_SIZE-1:0] st_data;
  logic [3:0]          st_be;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  assign idx      = bus.addr[ADDR_WIDTH-1:2];
  assign off      = bus.addr[1:0];
  assign accept   = bus.req && (state_q == StIdle);
  assign do_store = accept && bus.we && !misalign;
  assign do_load  = accept && !bus.we && !misalign;

  always_comb begin
    misalign = 1'b1;
    unique case (bus.size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = off[0];
      2'b10:   misalign = (off != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  // The previous edge's store is already in the array, so store-then-load needs no bypass.
  assign rd_word = mem[idx];
  assign ld_byte = rd_word[{off, 3'b000} +: 8];
  assign ld_half = rd_word[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = rd_word;
    unique case (bus.size)
      2'b00:   ld_data = bus.unsignedLd ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = bus.unsignedLd ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // Replicate the right-aligned store data across lanes; the enables pick the live ones.
  always_comb begin
    st_data = bus.writeData;
    st_be   = 4'b1111;
    unique case (bus.size)
      2'b00: begin
        st_data = {4{bus.writeData[7:0]}};
        st_be   = 4'b0001 << off;
      end
      2'b01: begin
        st_data = {2{bus.writeData[15:0]}};
        st_be   = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = bus.writeData;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_ptr_q   <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_valid_q <= do_load;
      err_q      <= accept && misalign;
      if (do_load) begin
        read_data_q <= ld_data;
      end
      if (state_q == StClear) begin
        clr_ptr_q <= clr_ptr_q + IdxW'(1);
        if (clr_ptr_q == LastIdx) begin
          state_q <= StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_ptr_q] <= '0;
    end else if (do_store) begin
      for (int k = 0; k < 4; k++) begin
        if (st_be[k]) begin
          mem[idx][8*k +: 8] <= st_data[8*k +: 8];
        end
      end
    end
  end

  assign bus.readData = read_data_q;
  assign bus.rdValid  = rd_valid_q;
  assign bus.err      = err_q;
  assign bus.ready    = (state_q == StIdle);
endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: byte-array reference model checked every cycle, plus
// directed vectors with literal expectations.
module tb_dmem_bytelane;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic cmp_en = 1'b0;

  dmem_bytelane_if #(.BUS_SIZE(32), .ADDR_WIDTH(8)) bus ();

  dmem_bytelane #(.BUS_SIZE(32), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: flat byte array, edge counter for the clear phase.
  logic [7:0]  m_mem [256];
  int          m_cnt = 0;
  logic        e_ready = 1'b0;
  logic        e_valid = 1'b0;
  logic        e_err = 1'b0;
  logic [31:0] e_rd = '0;

  function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = m_mem[a];
    h = {m_mem[a+1], m_mem[a]};
    case (sz)
      2'd0:    return uns ? {24'h0, b} : 32'($signed(b));
      2'd1:    return uns ? {16'h0, h} : 32'($signed(h));
      default: return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int a;
    logic bad;
    if (!rst_n) begin
      m_cnt = 0; e_ready = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_rd = '0;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    end else if (!e_ready) begin
      e_valid = 1'b0; e_err = 1'b0;
      m_cnt++;
      if (m_cnt == 64) e_ready = 1'b1;
    end else begin
      e_valid = 1'b0; e_err = 1'b0;
      if (bus.req) begin
        a   = int'(bus.addr);
        bad = (bus.size == 2'd3) || (bus.size == 2'd1 && a % 2 != 0) ||
              (bus.size == 2'd2 && a % 4 != 0);
        if (bad) begin
          e_err = 1'b1;
        end else if (bus.we) begin
          for (int i = 0; i < (1 << bus.size); i++) m_mem[a+i] = bus.writeData[8*i +: 8];
        end else begin
          e_valid = 1'b1;
          e_rd    = model_load(a, bus.size, bus.unsignedLd);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_ready", {31'b0, bus.ready}, {31'b0, e_ready});
      check("cyc_rdValid", {31'b0, bus.rdValid}, {31'b0, e_valid});
      check("cyc_err", {31'b0, bus.err}, {31'b0, e_err});
      check("cyc_readData", bus.readData, e_rd);
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [7:0] a, input logic [31:0] wd);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.unsignedLd = uns;
    bus.addr = a; bus.writeData = wd;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [1:0] sz, input logic uns,
                          input logic [7:0] a, input logic [31:0] exp);
    drive(1'b0, sz, uns, a, 32'h0);
    check(name, bus.readData, exp);
    check({name, "_valid"}, {31'b0, bus.rdValid}, 32'd1);
  endtask

  task automatic bad_chk(input string name, input logic w, input logic [1:0] sz,
                         input logic [7:0] a, input logic [31:0] prev);
    drive(w, sz, 1'b0, a, 32'h0);
    check({name, "_err"}, {31'b0, bus.err}, 32'd1);
    check({name, "_valid"}, {31'b0, bus.rdValid}, 32'd0);
    check({name, "_hold"}, bus.readData, prev);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.unsignedLd = 1'b0;
    bus.addr = '0; bus.writeData = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_readData", bus.readData, 32'h0);
    check("rst_rdValid", {31'b0, bus.rdValid}, 32'd0);
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("clear_edges_first", n, 32'd64);

    // Dirty some words, then reset mid-run and confirm the clear wipes them.
    drive(1'b1, 2'b10, 1'b0, 8'h00, 32'hFFFF_FFFF);
    drive(1'b1, 2'b10, 1'b0, 8'h14, 32'hFFFF_FFFF);
    drive(1'b1, 2'b10, 1'b0, 8'hFC, 32'hFFFF_FFFF);
    load_chk("lw14_dirty", 2'b10, 1'b0, 8'h14, 32'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("clear_edges_midrun", n, 32'd64);
    load_chk("lw00_clr", 2'b10, 1'b0, 8'h00, 32'h0);
    load_chk("lw14_clr", 2'b10, 1'b0, 8'h14, 32'h0);
    load_chk("lwFC_clr", 2'b10, 1'b0, 8'hFC, 32'h0);

    // Reset mid-clear with a store held on the bus throughout.
    drive(1'b1, 2'b10, 1'b0, 8'h08, 32'h1234_5678);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 8'h08;
    bus.writeData = 32'hFFFF_FFFF;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    bus.req = 1'b0;
    check("clear_edges_restart", n, 32'd64);
    check("clear_req_err", {31'b0, bus.err}, 32'd0);
    load_chk("lw08_clr", 2'b10, 1'b0, 8'h08, 32'h0);

    drive(1'b1, 2'b10, 1'b0, 8'h10, 32'h1122_3344);
    drive(1'b1, 2'b00, 1'b0, 8'h11, 32'h0000_00AA);
    drive(1'b1, 2'b01, 1'b0, 8'h12, 32'h0000_BEEF);
    load_chk("lanes_lw10", 2'b10, 1'b0, 8'h10, 32'hBEEF_AA44);

    drive(1'b1, 2'b10, 1'b0, 8'h20, 32'h80FF_7F01);
    load_chk("lb22", 2'b00, 1'b0, 8'h22, 32'hFFFF_FFFF);
    load_chk("lbu22", 2'b00, 1'b1, 8'h22, 32'h0000_00FF);
    load_chk("lh22", 2'b01, 1'b0, 8'h22, 32'hFFFF_80FF);
    load_chk("lhu22", 2'b01, 1'b1, 8'h22, 32'h0000_80FF);
    load_chk("lb20", 2'b00, 1'b0, 8'h20, 32'h0000_0001);

    bad_chk("sh21", 1'b1, 2'b01, 8'h21, 32'h0000_0001);
    bad_chk("sw22", 1'b1, 2'b10, 8'h22, 32'h0000_0001);
    bad_chk("lw23", 1'b0, 2'b10, 8'h23, 32'h0000_0001);
    bad_chk("size11", 1'b1, 2'b11, 8'h20, 32'h0000_0001);
    bad_chk("size11_rpt", 1'b0, 2'b11, 8'h20, 32'h0000_0001);
    load_chk("lw20_intact", 2'b10, 1'b0, 8'h20, 32'h80FF_7F01);

    drive(1'b1, 2'b10, 1'b0, 8'h44, 32'h5A5A_1234);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 8'h40;
    bus.writeData = 32'hCAFE_F00D;
    @(negedge clk);
    bus.we = 1'b0;
    @(negedge clk);
    check("b2b_first", bus.readData, 32'hCAFE_F00D);
    check("b2b_first_valid", {31'b0, bus.rdValid}, 32'd1);
    bus.addr = 8'h44;
    @(negedge clk);
    bus.req = 1'b0;
    check("b2b_second", bus.readData, 32'h5A5A_1234);
    check("b2b_second_valid", {31'b0, bus.rdValid}, 32'd1);
    @(negedge clk);
    check("b2b_drop_valid", {31'b0, bus.rdValid}, 32'd0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
